// File: rtl/mix_sample_fetcher.sv
// mix_sample_fetcher
//
// Request side of the voice-mixer sample handshake. A free-running tick
// counter paces requests at the audio rate. Each request is a one-cycle
// pulse on generate_new_sample to the mixer. The 16-bit sample returned with
// new_sample_ready is captured into a small first-word-fall-through FIFO,
// which the codec/DAC serializer drains through a valid/ready interface.
//
// Parameters:
//   DIVIDER    clk cycles per sample period (>= 4)
//   FIFO_DEPTH output FIFO entries (power of two, 2..16)
//   TIMEOUT    max WAIT cycles before a request is abandoned
//
// Ports:
//   clk                 single clock, rising edge
//   reset_n             synchronous active-low reset
//   generate_new_sample one-cycle request pulse to the mixer
//   new_sample_ready    mixer response, mixed_sample valid this cycle
//   mixed_sample        signed 16-bit mixed sample
//   out_sample          FIFO head, zero when the FIFO is empty
//   out_valid           FIFO non-empty
//   out_ready           consumer accepts head when out_valid is high
//   fifo_level          current FIFO occupancy
//   overflow            sticky: a sample was dropped on a full FIFO
//   late_tick           sticky: a tick arrived while a request was outstanding
//   timeout_err         sticky: a request timed out
//
// Configuration macro: MIX_TIMEOUT_EN
//   defined   -> WAIT is bounded by TIMEOUT cycles, timeout_err is live
//   undefined -> WAIT holds until new_sample_ready, timeout_err is 0

module mix_sample_fetcher #(
    parameter int DIVIDER    = 2083,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          generate_new_sample,
    input  logic                          new_sample_ready,
    input  logic [15:0]                   mixed_sample,
    output logic [15:0]                   out_sample,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          late_tick,
    output logic                          timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIVIDER);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick_s;

    logic            push_s;
    logic            pop_s;
    logic            wr_en_s;
    logic            full_s;
    logic            empty_s;
    logic            late_set_s;
    logic            ovf_set_s;

    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [15:0]     head_d;

    logic            gen_q;
    logic            out_valid_q;
    logic [15:0]     out_sample_q;
    logic            overflow_q;
    logic            late_q;

`ifdef MIX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   wcnt_q, wcnt_d;
    logic            tout_set_s;
    logic            tout_q;
`endif

    // Pacing counter next value; wraps after DIVIDER-1 independent of the FSM.
    always_comb begin
        tick_s = (cnt_q == CW'(DIVIDER - 1));
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Request FSM next-state logic: pacing, response capture, late-tick detection.
    always_comb begin
        state_d    = state_q;
        push_s     = 1'b0;
        late_set_s = 1'b0;
`ifdef MIX_TIMEOUT_EN
        wcnt_d     = wcnt_q;
        tout_set_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                late_set_s = tick_s;
                state_d    = ST_WAIT;
`ifdef MIX_TIMEOUT_EN
                wcnt_d     = '0;
`endif
            end
            ST_WAIT: begin
                late_set_s = tick_s;
                if (new_sample_ready) begin
                    push_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
`ifdef MIX_TIMEOUT_EN
                    // Last allowed WAIT cycle without a response: abandon.
                    if (wcnt_q == TW'(TIMEOUT - 1)) begin
                        tout_set_s = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + TW'(1);
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO control: accept/drop decisions, pointer/level updates, next head.
    always_comb begin
        full_s    = (level_q == LW'(FIFO_DEPTH));
        empty_s   = (level_q == LW'(0));
        pop_s     = out_ready && !empty_s;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        wr_en_s   = push_s && (!full_s || pop_s);
        ovf_set_s = push_s && full_s && !pop_s;

        wr_ptr_d = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s   ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Head after this edge; the slot being written this cycle is not yet
        // in mem_q, so forward the incoming sample when it becomes the head.
        if (level_d == LW'(0)) begin
            head_d = 16'd0;
        end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = mixed_sample;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            gen_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sample_q <= 16'd0;
            overflow_q   <= 1'b0;
            late_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            gen_q        <= (state_d == ST_REQ);
            out_valid_q  <= (level_d != LW'(0));
            out_sample_q <= head_d;
            overflow_q   <= overflow_q | ovf_set_s;
            late_q       <= late_q | late_set_s;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= mixed_sample;
        end
    end

`ifdef MIX_TIMEOUT_EN
    // WAIT cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wcnt_q <= '0;
            tout_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            tout_q <= tout_q | tout_set_s;
        end
    end

    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign generate_new_sample = gen_q;
    assign out_valid           = out_valid_q;
    assign out_sample          = out_sample_q;
    assign fifo_level          = level_q;
    assign overflow            = overflow_q;
    assign late_tick           = late_q;

endmodule

// File: tb/tb_mix_sample_fetcher.sv
// Self-checking bench for mix_sample_fetcher (DIVIDER=8, FIFO_DEPTH=4,
// TIMEOUT=16). A behavioural model follows the sample period, request
// lifetime and FIFO contents with plain counters and a queue; every cycle the
// DUT outputs are compared with it, and directed scenarios add hand-computed
// literal expectations.

module tb_mix_sample_fetcher;

    localparam int DIVIDER    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 16;

    logic        clk;
    logic        reset_n;
    logic        generate_new_sample;
    logic        new_sample_ready;
    logic [15:0] mixed_sample;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        late_tick;
    logic        timeout_err;

    mix_sample_fetcher #(
        .DIVIDER    (DIVIDER),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .generate_new_sample (generate_new_sample),
        .new_sample_ready    (new_sample_ready),
        .mixed_sample        (mixed_sample),
        .out_sample          (out_sample),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .fifo_level          (fifo_level),
        .overflow            (overflow),
        .late_tick           (late_tick),
        .timeout_err         (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- mixer: two-flop request-to-response delay -------------
    logic        mix_en;
    logic        mix_inc;
    logic [15:0] mix_data;
    logic        force_ready;
    logic [15:0] force_data;
    logic [2:0]  sh;
    logic        mix_q;
    logic [15:0] mix_val;
    logic [15:0] served;

    initial begin
        sh      = 3'd0;
        mix_q   = 1'b0;
        mix_val = 16'd0;
        served  = 16'd0;
    end

    always @(negedge clk) begin
        sh = {sh[1:0], generate_new_sample};
        if (!mix_en) served = 16'd0;
        else if (sh[2]) served = served + 16'd1;
        mix_q   = sh[2];
        mix_val = mix_inc ? served : mix_data;
    end

    assign new_sample_ready = (mix_q && mix_en) || force_ready;
    assign mixed_sample     = force_ready ? force_data : mix_val;

    // ---------------- behavioural model --------------------------------------
    int          m_cyc;
    int          m_phase;   // 0 no request, 1 request cycle, 2 awaiting response
    int          m_wait;
    logic [15:0] m_q[$];
    bit          m_ovf, m_late, m_tout;
    bit          m_tick, m_push, m_pop, m_full;
    logic [15:0] m_pdata;

    initial begin
        m_cyc = 0; m_phase = 0; m_wait = 0;
        m_ovf = 1'b0; m_late = 1'b0; m_tout = 1'b0;
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            m_cyc = 0; m_phase = 0; m_wait = 0;
            m_q.delete();
            m_ovf = 1'b0; m_late = 1'b0; m_tout = 1'b0;
        end else begin
            m_tick  = ((m_cyc % DIVIDER) == DIVIDER - 1);
            m_cyc   = m_cyc + 1;
            m_push  = 1'b0;
            m_pdata = 16'd0;
            m_full  = (m_q.size() == FIFO_DEPTH);
            m_pop   = out_ready && (m_q.size() != 0);
            if (m_phase == 0) begin
                if (m_tick) m_phase = 1;
            end else if (m_phase == 1) begin
                if (m_tick) m_late = 1'b1;
                m_phase = 2;
                m_wait  = 0;
            end else begin
                if (m_tick) m_late = 1'b1;
                if (new_sample_ready) begin
                    m_push  = 1'b1;
                    m_pdata = mixed_sample;
                    m_phase = 0;
                end else begin
`ifdef MIX_TIMEOUT_EN
                    m_wait = m_wait + 1;
                    if (m_wait == TIMEOUT) begin
                        m_tout  = 1'b1;
                        m_phase = 0;
                    end
`endif
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_full && !m_pop) m_ovf = 1'b1;
                else m_q.push_back(m_pdata);
            end
        end
    end

    // ---------------- checking ----------------------------------------------
    int total;
    int bad;
    bit chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [15:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 16'd0;
        chk("gen",      32'(generate_new_sample), 32'(m_phase == 1));
        chk("valid",    32'(out_valid),           32'(m_q.size() != 0));
        chk("sample",   32'(out_sample),          32'(head));
        chk("level",    32'(fifo_level),          32'(m_q.size()));
        chk("overflow", 32'(overflow),            32'(m_ovf));
        chk("late",     32'(late_tick),           32'(m_late));
        chk("timeout",  32'(timeout_err),         32'(m_tout));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (chk_en) compare();
        end
    endtask

    task automatic wait_gen();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1);
            if (generate_new_sample) seen = 1'b1;
        end
        chk("wait_gen_bound", 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        mix_en      = 1'b0;
        force_ready = 1'b0;
        reset_n     = 1'b0;
        step(1);
        step(1);
        reset_n     = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        reset_n = 1'b0; out_ready = 1'b1;
        mix_en = 1'b0; mix_inc = 1'b0; mix_data = 16'd0;
        force_ready = 1'b0; force_data = 16'd0;
        do_reset();
        chk_en = 1'b1;

        // Reset state
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);

        // 1: steady pacing with a constant sample, consumer always ready
        mix_data = 16'h1234; mix_inc = 1'b0; mix_en = 1'b1; out_ready = 1'b1;
        wait_gen();
        step(1);
        chk("s1_pulse_width", 32'(generate_new_sample), 32'd0);
        step(2);
        chk("s1_valid", 32'(out_valid), 32'd1);
        chk("s1_sample", 32'(out_sample), 32'h1234);
        step(1);
        chk("s1_valid_drop", 32'(out_valid), 32'd0);
        step(4);
        chk("s1_next_pulse", 32'(generate_new_sample), 32'd1);

        // 2: fill with samples 1..6, consumer stalled, then drain
        do_reset();
        out_ready = 1'b0; mix_inc = 1'b1; mix_en = 1'b1;
        for (int k = 0; k < 6; k++) wait_gen();
        step(4);
        chk("s2_level", 32'(fifo_level), 32'd4);
        chk("s2_overflow", 32'(overflow), 32'd1);
        chk("s2_head", 32'(out_sample), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("s2_drain", 32'(out_sample), 32'(i));
            step(1);
        end
        chk("s2_empty_sample", 32'(out_sample), 32'd0);
        mix_en = 1'b0;

        // 3: push and pop in the same cycle on a full FIFO
        do_reset();
        out_ready = 1'b0; mix_inc = 1'b1; mix_en = 1'b1;
        for (int k = 0; k < 5; k++) wait_gen();
        step(2);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("s3_level", 32'(fifo_level), 32'd4);
        chk("s3_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("s3_order", 32'(out_sample), 32'(i));
            step(1);
        end

        // 4: mixer withheld
        do_reset();
        out_ready = 1'b1;
        wait_gen();
`ifdef MIX_TIMEOUT_EN
        step(16);
        chk("s4_tout_early", 32'(timeout_err), 32'd0);
        step(1);
        chk("s4_tout", 32'(timeout_err), 32'd1);
        step(7);
        chk("s4_new_req", 32'(generate_new_sample), 32'd1);
`else
        step(20);
        chk("s4_tout_off", 32'(timeout_err), 32'd0);
        chk("s4_no_req", 32'(generate_new_sample), 32'd0);
`endif
        chk("s4_late", 32'(late_tick), 32'd1);

        // 5: reset between request and response with two entries queued
        do_reset();
        out_ready = 1'b0; mix_inc = 1'b1; mix_en = 1'b1;
        for (int k = 0; k < 3; k++) wait_gen();
        chk("s5_level_pre", 32'(fifo_level), 32'd2);
        step(1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("s5_gen", 32'(generate_new_sample), 32'd0);
        chk("s5_valid", 32'(out_valid), 32'd0);
        chk("s5_sample", 32'(out_sample), 32'd0);
        chk("s5_level", 32'(fifo_level), 32'd0);
        chk("s5_flags", 32'({overflow, late_tick, timeout_err}), 32'd0);
        step(6);
        chk("s5_level_hold", 32'(fifo_level), 32'd0);
        wait_gen();
        step(3);
        chk("s5_level_new", 32'(fifo_level), 32'd1);
        chk("s5_sample_new", 32'(out_sample), 32'd4);

        // 6: spurious ready while idle
        do_reset();
        out_ready = 1'b0;
        step(2);
        force_data  = 16'hFFFF;
        force_ready = 1'b1;
        step(1);
        force_ready = 1'b0;
        chk("s6_level", 32'(fifo_level), 32'd0);
        chk("s6_valid", 32'(out_valid), 32'd0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_sample_fetcher.md
# mix_sample_fetcher

Request side of the voice-mixer sample handshake. Paces sample requests at the audio rate by pulsing `generate_new_sample` to the mixer and capturing the 16-bit mixed sample when `new_sample_ready` returns. Captured samples go into a small first-word-fall-through FIFO, which the codec/DAC serializer drains through a valid/ready interface. Sits between the mixer and the audio output stage.

## Interface

- `DIVIDER`, 2083: clk cycles per sample period (100 MHz / 2083 ≈ 48 kHz); must be ≥ 4.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, 2..16.
- `TIMEOUT`, 16: max cycles spent in WAIT before abandoning a request (used only with `MIX_TIMEOUT_EN`).

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `generate_new_sample` out 1: one-cycle request pulse to the mixer.
- `new_sample_ready` in 1: mixer response; `mixed_sample` is valid in that cycle.
- `mixed_sample` in 16: signed two's-complement mixed sample.
- `out_sample` out 16: FIFO head; 16'd0 when the FIFO is empty.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head when `out_valid` is also high.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; a sample was dropped because the FIFO was full.
- `late_tick` out 1: sticky; a pacing tick arrived while a request was still outstanding.
- `timeout_err` out 1: sticky; a request timed out (tied 0 without `MIX_TIMEOUT_EN`).

## Operation

- Reset (`reset_n` low at an edge): tick counter=0, state=IDLE, FIFO emptied, all outputs 0 (`generate_new_sample`, `out_valid`, `out_sample`, `fifo_level`, `overflow`, `late_tick`, `timeout_err`). Reset wins over every other event, including mid-request; a pending request is abandoned and a later `new_sample_ready` is ignored.
- Tick counter: counts 0..DIVIDER-1 and wraps; `tick` is asserted when the count is DIVIDER-1. It runs free of FSM state.
- FSM:
  - IDLE: on `tick`, go to REQ.
  - REQ: `generate_new_sample`=1 for exactly this cycle; go to WAIT.
  - WAIT: on `new_sample_ready`, push `mixed_sample` and go to IDLE. With `MIX_TIMEOUT_EN`, after TIMEOUT WAIT cycles without ready, set `timeout_err`, push nothing, and go to IDLE.
- A `tick` seen in REQ or WAIT sets `late_tick` and is otherwise ignored; ticks are never queued.
- `new_sample_ready` seen in IDLE or REQ is ignored.
- FIFO push when full with no pop in the same cycle: the sample is discarded, `overflow` is set, and contents are unchanged.
- Push and pop in the same cycle: both occur, including when the FIFO is full; level is unchanged.
- Pop when empty: no effect.
- Pointers wrap modulo FIFO_DEPTH. Data is stored bit-exact with no arithmetic.
- Sticky flags clear only on reset.

## Timing

- Request latency: `generate_new_sample` rises the cycle after `tick` (FSM in IDLE).
- With the standard two-flop mixer, `new_sample_ready` arrives 2 cycles after the request. The sample is written on that edge, and `out_valid` and `out_sample` reflect it the following cycle if the FIFO was empty.
- Minimum request-to-request spacing is DIVIDER cycles. With nominal mixer latency, ticks never land in REQ/WAIT.
- `fifo_level` and `out_valid` update on the same edge as the push or pop.
- `out_sample` changes only on a push-to-empty, a pop, or reset.

## Configuration

- `MIX_TIMEOUT_EN` defined: WAIT has a cycle counter. On reaching TIMEOUT, the FSM returns to IDLE and sets `timeout_err`. Any late `new_sample_ready` is then ignored.
- `MIX_TIMEOUT_EN` undefined: the counter is not built. WAIT holds indefinitely until `new_sample_ready`, and `timeout_err` is constant 0.

## Test plan

- DIVIDER=8, FIFO_DEPTH=4, mixer modelled as a 2-cycle delay returning 16'h1234 with `out_ready`=1. Expected: `generate_new_sample` pulses every 8 cycles, one cycle wide, and `out_valid` is high for one cycle with `out_sample`=16'h1234 three cycles after each pulse.
- Same setup, `out_ready`=0, samples 1..6. Expected: `fifo_level` saturates at 4, `overflow` is set on the 5th sample, and `out_sample` still shows 1. Then with `out_ready`=1, the drain order is 1,2,3,4.
- FIFO full with push and pop in the same cycle. Expected: level stays 4 and the order is preserved with no `overflow`.
- Mixer withheld (`new_sample_ready` never asserted), `MIX_TIMEOUT_EN` defined, TIMEOUT=16. Expected: `timeout_err`=1 exactly 16 WAIT cycles after the request, and the next tick issues a new request. Without the macro, the FSM stays in WAIT, a tick sets `late_tick`, and `timeout_err` stays 0.
- `reset_n` low for one cycle between the request and the ready, with the FIFO holding 2 entries. Expected: all outputs are 0 the next cycle, the subsequent `new_sample_ready` is ignored, and `fifo_level` stays 0 until the next tick-driven sample.
- Ready asserted spuriously in IDLE with `mixed_sample`=16'hFFFF. Expected: no push, and `fifo_level` is unchanged.
